pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 122 ++++++++++++
 tb/tb_pipe_reg_chain.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: WIDTH-bit, DEPTH-stage register pipeline with valid/ready
// handshakes on both ends, per-stage valid bits, bubble collapsing and a
// registered occupancy count.
// Optional feature: define PIPE_REG_CHAIN_FLUSH_EN to add a 'flush' input that
// empties the chain (valid bits and count) without touching the data registers.
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef PIPE_REG_CHAIN_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  // Per-stage state: index 0 is the input side, DEPTH-1 the output side.
  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];

  // Upstream view of each stage (producer for stage 0, previous stage otherwise).
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // Per-stage ready: a stage may load when it is empty or its content moves on.
  logic [DEPTH-1:0] r;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          in_fire;
  logic          out_fire;
  logic          flush_w;

`ifdef PIPE_REG_CHAIN_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_up
      if (gi == 0) begin : g_first
        assign up_v[gi] = in_valid;
        assign up_d[gi] = in_data;
      end else begin : g_inner
        assign up_v[gi] = v_q[gi-1];
        assign up_d[gi] = d_q[gi-1];
      end
    end
  endgenerate

  // Ready ripples from the consumer back to the producer; an empty stage always
  // accepts, which is what lets words slide past bubbles while the output stalls.
  // in_valid never enters this chain, so in_ready has no path from in_valid.
  always_comb begin
    r = '0;
    r[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      r[i] = ~v_q[i] | r[i+1];
    end
  end

  assign in_fire  = in_valid & r[0];
  assign out_fire = v_q[DEPTH-1] & out_ready;

  // Occupancy changes by at most one per cycle; simultaneous in/out cancels.
  always_comb begin
    count_d = count_q;
    unique case ({in_fire, out_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage advance: valid follows upstream whenever the stage is ready; data only
  // loads for a real word so an empty stage keeps its stale contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_w) begin
          v_q[i] <= 1'b0;
        end else if (r[i]) begin
          v_q[i] <= up_v[i];
        end
        if (!flush_w && r[i] && up_v[i]) begin
          d_q[i] <= up_d[i];
        end
      end
    end
  end

  // Occupancy register; flush drops everything including a word offered this cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_w) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign in_ready  = r[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain (default build, WIDTH=8, DEPTH=4).
module tb_pipe_reg_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;
  logic [WIDTH-1:0] sb_q[$];

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus. Inputs are applied one unit after a rising
  // edge; in_ready and any output transfer are judged against the model
  // before the edge, count after it.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    logic             exp_ready;
    logic             ofire;
    logic [WIDTH-1:0] expd;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_ready = (m_cnt < DEPTH) || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (sb_q.size() == 0) begin
      check("out_valid_when_empty", {31'd0, out_valid}, 32'd0);
    end
    ofire = out_valid && ordy;
    if (ofire) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        expd = sb_q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, expd});
        $display("[TB] out word %02h (exp %02h)", out_data, expd);
      end
      m_cnt--;
    end
    if (iv && exp_ready) begin
      sb_q.push_back(id);
      m_cnt++;
      $display("[TB] in word %02h accepted", id);
    end
    @(posedge clk);
    #1;
    check("count", {29'd0, count}, 32'(m_cnt));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      step(1'b0, 8'h00, 1'b1);
    end
    check("drain_complete", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    m_cnt = 0;
  endtask

  initial begin
    // Reset with a word offered: must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'h00);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_count", {29'd0, count}, 32'd0);

    // Streaming with out_ready held high: AA accepted at edge 1 appears after edge 4.
    step(1'b1, 8'hAA, 1'b1);
    step(1'b1, 8'h6D, 1'b1);
    step(1'b1, 8'h25, 1'b1);
    check("stream_peak_count", {29'd0, count}, 32'd3);
    check("stream_not_yet_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("stream_lat_valid", {31'd0, out_valid}, 32'd1);
    check("stream_lat_data", {24'd0, out_data}, 32'hAA);
    drain();

    // Backpressure: four words fill the chain, the fifth is refused.
    step(1'b1, 8'h52, 1'b0);
    step(1'b1, 8'hBA, 1'b0);
    step(1'b1, 8'hC5, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    check("bp_full_count", {29'd0, count}, 32'd4);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {24'd0, out_data}, 32'h52);
    end
    drain();

    // Simultaneous in/out while full keeps count at DEPTH.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h11, 1'b1);
    check("full_passthru_count", {29'd0, count}, 32'd4);
    drain();

    // Bubble collapse: a lone word walks to the last stage while output stalls.
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("bubble_not_yet", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("bubble_arrive_valid", {31'd0, out_valid}, 32'd1);
    check("bubble_arrive_data", {24'd0, out_data}, 32'h5A);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("bubble_count2", {29'd0, count}, 32'd2);
    check("bubble_head_data", {24'd0, out_data}, 32'h5A);
    drain();

    // Mid-stream reset discards in-flight words.
    step(1'b1, 8'hE1, 1'b0);
    step(1'b1, 8'hE2, 1'b0);
    step(1'b1, 8'hE3, 1'b0);
    check("pre_rst_count", {29'd0, count}, 32'd3);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_cnt = 0;
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_not_yet", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", {24'd0, out_data}, 32'h77);
    drain();
    check("final_out_valid", {31'd0, out_valid}, 32'd0);
    check("final_count", {29'd0, count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
